// File: rtl/csa_accum_ctrl.sv
// ---------------------------------------------------------------------------
// csa_accum_ctrl
//   Sequencing controller for a row of 1-bit 4:2 carry-save compressor cells.
//   Each accepted beat folds an operand pair into a redundant (sum, carry)
//   state with no carry chain. After the last beat, a single carry-propagate
//   add resolves the state. The result is returned over a valid/ready
//   handshake.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   clear_i             synchronous abort back to IDLE (state zeroed)
//   in_valid_i/in_ready_o  operand beat handshake
//   in_a_i, in_b_i      unsigned operands (zero-extended to ACC_W)
//   in_b_en_i           0 treats in_b_i as zero for that beat
//   in_last_i           final beat of a reduction
//   out_valid_o/out_ready_i  result handshake
//   out_result_o        sum of accepted operands mod 2^ACC_W
//   out_beats_o         accepted beats, saturating
//   busy_o              high whenever not IDLE
// ---------------------------------------------------------------------------
module csa_accum_ctrl #(
    parameter int W     = 32,
    parameter int ACC_W = 40,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [W-1:0]     in_a_i,
    input  logic [W-1:0]     in_b_i,
    input  logic             in_b_en_i,
    input  logic             in_last_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [ACC_W-1:0] out_result_o,
    output logic [CNT_W-1:0] out_beats_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACC     = 2'd1,
        RESOLVE = 2'd2,
        OUT     = 2'd3
    } state_t;

    state_t state_r;
    state_t state_s;

    logic [ACC_W-1:0] sum_r;
    logic [ACC_W-1:0] carry_r;
    logic [ACC_W-1:0] out_result_r;
    logic [CNT_W-1:0] beat_cnt_r;
    logic [CNT_W-1:0] out_beats_r;
    logic             out_valid_r;

    logic             accept_s;
    logic             handshake_s;
    logic [ACC_W-1:0] a_ext_s;
    logic [ACC_W-1:0] b_ext_s;
    logic [ACC_W-1:0] op1_s;
    logic [ACC_W-1:0] op2_s;
    logic [ACC_W-1:0] row_sum_s;
    logic [ACC_W-1:0] row_c_s;
    logic [ACC_W-1:0] row_carry_s;
    logic [2:0]       cell_s;
    logic             e_s;
    logic [CNT_W-1:0] cnt_base_s;
    logic [CNT_W-1:0] cnt_next_s;

    // One 4:2 compressor cell; returns {e_out, c, s}.
    // o1+o2+o3+o4+e_in == s + 2*(c + e_out). e_out does not depend on e_in,
    // so the lateral chain is only one cell deep.
    function automatic logic [2:0] cmp42(
        input logic o1,
        input logic o2,
        input logic o3,
        input logic o4,
        input logic e_in
    );
        logic s1;
        logic e_out;
        logic c;
        logic s;
        s1    = o1 ^ o2 ^ o3;
        e_out = (o1 & o2) | (o1 & o3) | (o2 & o3);
        s     = s1 ^ o4 ^ e_in;
        c     = (s1 & o4) | (s1 & e_in) | (o4 & e_in);
        return {e_out, c, s};
    endfunction

    assign in_ready_o   = (state_r == IDLE) || (state_r == ACC);
    assign busy_o       = (state_r != IDLE);
    assign out_valid_o  = out_valid_r;
    assign out_result_o = out_result_r;
    assign out_beats_o  = out_beats_r;

    // A beat presented alongside clear_i is dropped.
    assign accept_s    = in_valid_i && in_ready_o && !clear_i;
    assign handshake_s = out_valid_r && out_ready_i;

    // Compressor row: operand selection and per-bit cell evaluation.
    always_comb begin
        a_ext_s     = ACC_W'(in_a_i);
        b_ext_s     = in_b_en_i ? ACC_W'(in_b_i) : {ACC_W{1'b0}};
        // A reduction started from IDLE always begins from a zero state.
        op1_s       = (state_r == IDLE) ? {ACC_W{1'b0}} : sum_r;
        op2_s       = (state_r == IDLE) ? {ACC_W{1'b0}} : carry_r;
        row_sum_s   = {ACC_W{1'b0}};
        row_c_s     = {ACC_W{1'b0}};
        cell_s      = 3'b000;
        e_s         = 1'b0;
        for (int i = 0; i < ACC_W; i++) begin
            cell_s       = cmp42(op1_s[i], op2_s[i], a_ext_s[i], b_ext_s[i], e_s);
            row_sum_s[i] = cell_s[0];
            row_c_s[i]   = cell_s[1];
            e_s          = cell_s[2];
        end
        // The carry weight is one bit up. The MSB carry and the final E fall off (mod 2^ACC_W).
        row_carry_s = row_c_s << 1;
    end

    // Saturating beat counter increment.
    always_comb begin
        cnt_base_s = (state_r == IDLE) ? {CNT_W{1'b0}} : beat_cnt_r;
        if (&cnt_base_s) begin
            cnt_next_s = cnt_base_s;
        end else begin
            cnt_next_s = cnt_base_s + CNT_W'(1'b1);
        end
    end

    // Next-state logic; clear_i overrides every transition.
    always_comb begin
        state_s = state_r;
        if (clear_i) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE, ACC: begin
                    if (accept_s) begin
                        state_s = in_last_i ? RESOLVE : ACC;
                    end else begin
                        state_s = state_r;
                    end
                end
                RESOLVE: state_s = OUT;
                OUT: begin
                    if (handshake_s) begin
                        state_s = IDLE;
                    end else begin
                        state_s = OUT;
                    end
                end
                default: state_s = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Redundant accumulator, beat counter and registered result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sum_r        <= {ACC_W{1'b0}};
            carry_r      <= {ACC_W{1'b0}};
            beat_cnt_r   <= {CNT_W{1'b0}};
            out_result_r <= {ACC_W{1'b0}};
            out_beats_r  <= {CNT_W{1'b0}};
            out_valid_r  <= 1'b0;
        end else if (clear_i) begin
            // The last result stays visible; everything else restarts.
            sum_r       <= {ACC_W{1'b0}};
            carry_r     <= {ACC_W{1'b0}};
            beat_cnt_r  <= {CNT_W{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            if (accept_s) begin
                sum_r      <= row_sum_s;
                carry_r    <= row_carry_s;
                beat_cnt_r <= cnt_next_s;
            end else if (handshake_s) begin
                sum_r      <= {ACC_W{1'b0}};
                carry_r    <= {ACC_W{1'b0}};
                beat_cnt_r <= {CNT_W{1'b0}};
            end else begin
                sum_r      <= sum_r;
                carry_r    <= carry_r;
                beat_cnt_r <= beat_cnt_r;
            end

            if (state_r == RESOLVE) begin
                out_result_r <= sum_r + carry_r;
                out_beats_r  <= beat_cnt_r;
                out_valid_r  <= 1'b1;
            end else if (handshake_s) begin
                out_valid_r  <= 1'b0;
            end else begin
                out_valid_r  <= out_valid_r;
            end
        end
    end

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// ---------------------------------------------------------------------------
// tb_csa_accum_ctrl
//   Directed self-checking bench for csa_accum_ctrl (W=32, ACC_W=40, CNT_W=8).
//   Inputs change and outputs are sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_csa_accum_ctrl;

    localparam int W     = 32;
    localparam int ACC_W = 40;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic             in_b_en;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_result;
    logic [CNT_W-1:0] out_beats;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [ACC_W-1:0] model;

    csa_accum_ctrl #(.W(W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (clear),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_a_i      (in_a),
        .in_b_i      (in_b),
        .in_b_en_i   (in_b_en),
        .in_last_i   (in_last),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_result_o(out_result),
        .out_beats_o (out_beats),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic b_en, input logic last);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_b_en  = b_en;
        in_last  = last;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_b_en  = 1'b0;
        in_last  = 1'b0;
    endtask

    // Bounded wait for out_valid; an expired bound is reported as a failure.
    task automatic wait_valid(input string tag, input int bound);
        for (int i = 0; i < bound && out_valid !== 1'b1; i++) tick();
        check_eq(tag, 64'(out_valid), 64'd1);
    endtask

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        out_ready = 1'b0;
        idle_inputs();
        tick();
        tick();

        // Reset state
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_busy",      64'(busy),      64'd0);
        check_eq("rst_in_ready",  64'(in_ready),  64'd1);
        check_eq("rst_result",    64'(out_result), 64'd0);
        check_eq("rst_beats",     64'(out_beats), 64'd0);
        rst = 1'b0;
        tick();

        // Single beat: 5 + 7, valid two cycles after acceptance
        out_ready = 1'b1;
        drive_beat(32'd5, 32'd7, 1'b1, 1'b1);
        check_eq("single_in_ready", 64'(in_ready), 64'd1);
        tick();
        idle_inputs();
        check_eq("single_resolve_valid", 64'(out_valid), 64'd0);
        check_eq("single_resolve_busy",  64'(busy),      64'd1);
        check_eq("single_resolve_ready", 64'(in_ready),  64'd0);
        tick();
        check_eq("single_valid",  64'(out_valid),  64'd1);
        check_eq("single_result", 64'(out_result), 64'd12);
        check_eq("single_beats",  64'(out_beats),  64'd1);
        tick();
        check_eq("single_done_valid", 64'(out_valid), 64'd0);
        check_eq("single_done_busy",  64'(busy),      64'd0);

        // Four beats, last one with b disabled: 1+2+3+4+5+6+7 = 28
        drive_beat(32'd1, 32'd2, 1'b1, 1'b0);
        check_eq("four_ready1", 64'(in_ready), 64'd1);
        tick();
        drive_beat(32'd3, 32'd4, 1'b1, 1'b0);
        check_eq("four_ready2", 64'(in_ready), 64'd1);
        tick();
        drive_beat(32'd5, 32'd6, 1'b1, 1'b0);
        check_eq("four_ready3", 64'(in_ready), 64'd1);
        tick();
        drive_beat(32'd7, 32'h0000_FFFF, 1'b0, 1'b1);
        check_eq("four_ready4", 64'(in_ready), 64'd1);
        tick();
        idle_inputs();
        wait_valid("four_valid", 4);
        check_eq("four_result", 64'(out_result), 64'd28);
        check_eq("four_beats",  64'(out_beats),  64'd4);
        tick();

        // Wrap-around: 300 beats of all-ones pairs against a running model
        model = '0;
        for (int k = 0; k < 300; k++) begin
            drive_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, (k == 299) ? 1'b1 : 1'b0);
            model = model + {8'h00, 32'hFFFF_FFFF} + {8'h00, 32'hFFFF_FFFF};
            tick();
        end
        idle_inputs();
        wait_valid("wrap_valid", 4);
        check_eq("wrap_model_const", 64'(model), 64'd377957121448);
        check_eq("wrap_result", 64'(out_result), 64'(model));
        check_eq("wrap_beats",  64'(out_beats),  64'd255);
        tick();

        // Output backpressure with a beat pending at the input
        out_ready = 1'b0;
        drive_beat(32'd100, 32'd23, 1'b1, 1'b1);
        tick();
        idle_inputs();
        tick();
        drive_beat(32'd40, 32'd2, 1'b1, 1'b1);
        for (int k = 0; k < 10; k++) begin
            check_eq("bp_valid",    64'(out_valid),  64'd1);
            check_eq("bp_result",   64'(out_result), 64'd123);
            check_eq("bp_in_ready", 64'(in_ready),   64'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check_eq("bp_idle_valid", 64'(out_valid), 64'd0);
        check_eq("bp_idle_ready", 64'(in_ready),  64'd1);
        check_eq("bp_idle_busy",  64'(busy),      64'd0);
        tick();
        idle_inputs();
        wait_valid("bp2_valid", 4);
        check_eq("bp2_result", 64'(out_result), 64'd42);
        check_eq("bp2_beats",  64'(out_beats),  64'd1);
        tick();

        // clear_i mid-ACC drops the concurrent beat
        drive_beat(32'd1, 32'd1, 1'b1, 1'b0);
        tick();
        drive_beat(32'd2, 32'd2, 1'b1, 1'b0);
        tick();
        drive_beat(32'd50, 32'd50, 1'b1, 1'b1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        idle_inputs();
        check_eq("clr_busy",   64'(busy),       64'd0);
        check_eq("clr_valid",  64'(out_valid),  64'd0);
        check_eq("clr_ready",  64'(in_ready),   64'd1);
        check_eq("clr_result", 64'(out_result), 64'd42);
        tick();
        check_eq("clr_no_accept", 64'(busy), 64'd0);
        drive_beat(32'd10, 32'd20, 1'b1, 1'b1);
        tick();
        idle_inputs();
        wait_valid("clr2_valid", 4);
        check_eq("clr2_result", 64'(out_result), 64'd30);
        check_eq("clr2_beats",  64'(out_beats),  64'd1);
        tick();

        // Reset in OUT
        out_ready = 1'b0;
        drive_beat(32'd3, 32'd4, 1'b1, 1'b1);
        tick();
        idle_inputs();
        tick();
        check_eq("rout_pre_valid",  64'(out_valid),  64'd1);
        check_eq("rout_pre_result", 64'(out_result), 64'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rout_valid",  64'(out_valid),  64'd0);
        check_eq("rout_busy",   64'(busy),       64'd0);
        check_eq("rout_ready",  64'(in_ready),   64'd1);
        check_eq("rout_result", 64'(out_result), 64'd0);

        // Reset in RESOLVE, after a nonzero result is on the output
        out_ready = 1'b1;
        drive_beat(32'd5, 32'd6, 1'b1, 1'b1);
        tick();
        idle_inputs();
        wait_valid("rres_pre_valid", 4);
        check_eq("rres_pre_result", 64'(out_result), 64'd11);
        tick();
        drive_beat(32'd9, 32'd9, 1'b1, 1'b1);
        tick();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rres_valid",  64'(out_valid),  64'd0);
        check_eq("rres_busy",   64'(busy),       64'd0);
        check_eq("rres_ready",  64'(in_ready),   64'd1);
        check_eq("rres_result", 64'(out_result), 64'd0);
        check_eq("rres_beats",  64'(out_beats),  64'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
